// File: rtl/mips_muldiv_unit_if.sv
// Command/result bundle between the EX stage and the multiply/divide unit.
interface mips_muldiv_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  flush;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] hi;
   logic [DATA_WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Magnitudes are processed unsigned; signs are applied once in the FINISH cycle.
module mips_muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   mips_muldiv_unit_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int CW = $clog2(DW + 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [DW-1:0]   opnd_q, opnd_d;
   logic [DW-1:0]   araw_q, araw_d;
   logic            is_div_q, is_div_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            bzero_q, bzero_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [DW-1:0]   hi_q, hi_d;
   logic [DW-1:0]   lo_q, lo_d;

   // Operand conditioning for the command currently presented.
   logic            signed_op, a_neg, b_neg;
   logic [DW-1:0]   a_mag, b_mag;

   assign signed_op = ~bus.op[0];
   assign a_neg     = signed_op & bus.a[DW-1];
   assign b_neg     = signed_op & bus.b[DW-1];
   assign a_mag     = a_neg ? -bus.a : bus.a;
   assign b_mag     = b_neg ? -bus.b : bus.b;

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   logic [DW:0]     mul_sum;
   logic [DW:0]     div_sh, div_diff;
   logic [2*DW-1:0] mul_next, div_next, prod_neg;
   logic [DW-1:0]   quot, rem;

   assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, opnd_q & {DW{acc_q[0]}}};
   assign mul_next = {mul_sum, acc_q[DW-1:1]};
   assign div_sh   = acc_q[2*DW-1:DW-1];
   assign div_diff = div_sh - {1'b0, opnd_q};
   assign div_next = div_diff[DW] ? {div_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                                  : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
   assign prod_neg = -acc_q;
   assign quot     = acc_q[DW-1:0];
   assign rem      = acc_q[2*DW-1:DW];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      araw_d   = araw_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      bzero_d  = bzero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.flush) begin
               case (bus.op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d = bus.op[1];
                     qneg_d   = a_neg ^ b_neg;
                     rneg_d   = a_neg;
                     bzero_d  = (bus.b == '0);
                     araw_d   = bus.a;
                     acc_d    = bus.op[1] ? {{DW{1'b0}}, a_mag} : {{DW{1'b0}}, b_mag};
                     opnd_d   = bus.op[1] ? b_mag : a_mag;
                     cnt_d    = CW'(DW);
                     busy_d   = 1'b1;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            if (bus.flush) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1))
                  state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = qneg_q ? prod_neg : acc_q;
               end else if (bzero_q) begin
                  hi_d = araw_q;
                  lo_d = '1;
               end else begin
                  lo_d = qneg_q ? -quot : quot;
                  hi_d = rneg_q ? -rem : rem;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         araw_q   <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         bzero_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         araw_q   <= araw_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         bzero_q  <= bzero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: cycle-level reference model plus hand-computed results.
module tb_mips_muldiv_unit;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic chk_en = 1'b0;

   mips_muldiv_unit_if #(.DATA_WIDTH(DW)) bus();

   mips_muldiv_unit #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} of a mult/div command, from plain arithmetic.
   function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int sa, sb, q, m;
      r = '0;
      case (op)
         3'd0: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         3'd1: r = {32'h0, a} * {32'h0, b};
         3'd2: begin
            sa = a;
            sb = b;
            if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
            else begin
               q = sa / sb;
               m = sa % sb;
               r = {m, q};
            end
         end
         3'd3: begin
            if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [63:0] c_res;
   assign c_res = model_res(bus.op, bus.a, bus.b);

   // Reference: a mult/div owes its writeback DW+1 edges after acceptance.
   logic        m_busy = 1'b0, m_done = 1'b0;
   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   int          m_cnt = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
         m_cnt  <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (bus.flush) m_busy <= 1'b0;
            else if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= p_hi;
               m_lo   <= p_lo;
               m_cnt  <= 0;
            end else m_cnt <= m_cnt - 1;
         end else if (bus.start && !bus.flush) begin
            if (bus.op <= 3'd3) begin
               m_busy <= 1'b1;
               m_cnt  <= DW + 1;
               p_hi   <= c_res[63:32];
               p_lo   <= c_res[31:0];
            end else if (bus.op == 3'd4) m_hi <= bus.a;
            else if (bus.op == 3'd5) m_lo <= bus.a;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {63'h0, bus.busy}, {63'h0, m_busy});
         chk("done", {63'h0, bus.done}, {63'h0, m_done});
         chk("hi", {32'h0, bus.hi}, {32'h0, m_hi});
         chk("lo", {32'h0, bus.lo}, {32'h0, m_lo});
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.flush = fl;
      @(negedge clk);
      bus.start = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int lat;
      lat = 0;
      while (!bus.done && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, 64'(lat), 64'd33);
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      issue(op, a, b, 1'b0);
      wait_done(name);
      chk({name, "_hi"}, {32'h0, bus.hi}, {32'h0, exp_hi});
      chk({name, "_lo"}, {32'h0, bus.lo}, {32'h0, exp_lo});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      bus.flush = 1'b0;
      #1 reset = 1'b0;
      #2;
      chk("rst_busy", {63'h0, bus.busy}, 64'h0);
      chk("rst_done", {63'h0, bus.done}, 64'h0);
      chk("rst_hi", {32'h0, bus.hi}, 64'h0);
      chk("rst_lo", {32'h0, bus.lo}, 64'h0);
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;

      run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op("divu_by0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div_m7_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      issue(3'd4, 32'h1234_5678, 32'h0, 1'b0);
      chk("mthi_hi", {32'h0, bus.hi}, 64'h1234_5678);
      chk("mthi_busy", {63'h0, bus.busy}, 64'h0);
      chk("mthi_done", {63'h0, bus.done}, 64'h0);

      issue(3'd0, 32'd2, 32'd2, 1'b0);
      repeat (3) @(negedge clk);
      issue(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b0);
      chk("mtlo_busy_lo", {32'h0, bus.lo}, 64'hFFFF_FFFF);
      chk("mtlo_busy_busy", {63'h0, bus.busy}, 64'h1);
      while (!bus.done && checks < 100000) @(negedge clk);
      chk("mult_2x2_lo", {32'h0, bus.lo}, 64'h4);

      issue(3'd4, 32'hAAAA_AAAA, 32'h0, 1'b0);
      issue(3'd5, 32'hAAAA_AAAA, 32'h0, 1'b0);
      issue(3'd0, 32'd5, 32'd6, 1'b0);
      repeat (8) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_busy", {63'h0, bus.busy}, 64'h0);
      chk("flush_done", {63'h0, bus.done}, 64'h0);
      chk("flush_hi", {32'h0, bus.hi}, 64'hAAAA_AAAA);
      chk("flush_lo", {32'h0, bus.lo}, 64'hAAAA_AAAA);
      repeat (40) @(negedge clk);
      run_op("multu_3x4", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

      issue(3'd4, 32'h55, 32'h0, 1'b1);
      chk("flush_idle_mthi", {32'h0, bus.hi}, 64'h0);

      // Flush landing exactly on the writeback edge.
      issue(3'd0, 32'd7, 32'd7, 1'b0);
      repeat (32) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_fin_done", {63'h0, bus.done}, 64'h0);
      chk("flush_fin_lo", {32'h0, bus.lo}, 64'd12);
      chk("flush_fin_busy", {63'h0, bus.busy}, 64'h0);

      issue(3'd2, 32'd1000, 32'd3, 1'b0);
      repeat (19) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", {63'h0, bus.busy}, 64'h0);
      chk("midrst_done", {63'h0, bus.done}, 64'h0);
      chk("midrst_hi", {32'h0, bus.hi}, 64'h0);
      chk("midrst_lo", {32'h0, bus.lo}, 64'h0);
      @(negedge clk);
      reset = 1'b1;

      run_op("b2b_multu_2x3", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6);
      bus.start = 1'b1;
      bus.op    = 3'd3;
      bus.a     = 32'd9;
      bus.b     = 32'd2;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy", {63'h0, bus.busy}, 64'h1);
      wait_done("b2b_divu_9_2");
      chk("b2b_divu_hi", {32'h0, bus.hi}, 64'h1);
      chk("b2b_divu_lo", {32'h0, bus.lo}, 64'h4);

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core, generalised in data width. It sits beside the ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands through a start/busy handshake and holds the pipeline via `busy` while an operation runs. HI/LO are read combinationally for MFHI/MFLO, and a `flush` input lets branch/jump squashing abort an in-flight operation.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width; must be even and ≥4.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: command valid; sampled only when `busy`=0.
- `op` input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 have no effect.
- `a` input DATA_WIDTH: rs operand (multiplicand / dividend / MTHI-MTLO data).
- `b` input DATA_WIDTH: rt operand (multiplier / divisor).
- `flush` input 1: abort any in-flight operation.
- `busy` output 1: operation in progress; the hazard unit stalls IF/ID/EX while it is high.
- `done` output 1: one-cycle pulse when HI/LO have been updated by a mult/div.
- `hi` output DATA_WIDTH: HI register.
- `lo` output DATA_WIDTH: LO register.

## Operation
- **States:** IDLE, RUN, FINISH.
- **IDLE + start + MULT/MULTU/DIV/DIVU:**
  - Latch operand magnitudes. Signed ops take the two's-complement absolute value. Record the result signs.
  - Load iteration counter = DATA_WIDTH, then go to RUN.
- **IDLE + start + MTHI/MTLO:** write `a` into `hi`/`lo` at that edge. Stay in IDLE. No `busy`, no `done`.
- **RUN:**
  - One radix-2 step per cycle, counter decrements.
  - Multiply uses shift-add into a 2·DATA_WIDTH accumulator.
  - Divide uses restoring shift-subtract, producing quotient and remainder.
  - Counter reaching 0 → FINISH.
- **FINISH:**
  - Apply sign correction and write `hi`/`lo`, pulse `done`, return to IDLE.
  - Multiply: {hi,lo} = full 2·DATA_WIDTH product, negated if the operand signs differ (signed op).
  - Divide: lo = quotient truncated toward zero, hi = remainder with the dividend's sign.
  - Signed most-negative ÷ −1: lo = most-negative value (wraps), hi = 0.
  - Divide by zero (signed or unsigned): lo = all ones, hi = `a` unchanged. Takes the full latency.
- **start while busy:** ignored. Commands are not queued.
- **flush:**
  - In RUN or FINISH: go to IDLE at the next edge. `hi`/`lo` keep their prior values and `done` is not asserted.
  - In IDLE with start: the command is dropped, including MTHI/MTLO.
  - flush has priority over start and over the FINISH writeback.
- **reset low (any time, including mid-operation):** state = IDLE; `hi`, `lo`, counter and datapath registers = 0; `busy`=0, `done`=0.

## Timing
- Start accepted at edge E0 → `busy`=1 from after E0.
- RUN spans edges E1..E_DATA_WIDTH; FINISH writes at edge E(DATA_WIDTH+1).
- After E(DATA_WIDTH+1): `busy`=0, `done`=1 for exactly one cycle, and new `hi`/`lo` are visible. Total mult/div latency is DATA_WIDTH+1 cycles (33 for the default).
- `busy` is registered and is high exactly DATA_WIDTH+1 cycles per uninterrupted op.
- A new `start` is accepted in the cycle `done` is high (back-to-back issue).
- MTHI/MTLO latency is 1 edge; the value is readable the next cycle.
- `hi`/`lo` never change except at FINISH, MTHI/MTLO, or reset.
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.

## Test plan
- **Signed MULT:** a=0xFFFFFFFD (−3), b=7 → after 33 cycles, `done` pulse, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- **MULTU:** a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- **Division mix:**
  - DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 100/7 → lo=0x0000000E, hi=0x00000002.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- **MTHI/MTLO and busy handling:**
  - MTHI 0x12345678 → hi updated the next cycle, `busy`=0, no `done`.
  - MTLO issued while `busy` → ignored, lo unchanged.
- **Flush mid-op:** preload hi=lo=0xAAAAAAAA, start MULT, assert `flush` at cycle 10 → `busy`=0 next cycle, no `done`, hi/lo still 0xAAAAAAAA. An immediate new MULTU 3×4 gives lo=12, hi=0.
- **Reset mid-op and back-to-back:**
  - Drive `reset` low at cycle 20 of a DIV → `busy`, `done`, `hi`, `lo` all 0 immediately, without a clock edge.
  - After release, issue MULTU 2×3 and a DIVU 9/2 asserted in the `done` cycle → results lo=6 then lo=4, hi=1, with 33-cycle spacing.
